// File: rtl/sequence_to_bayer.sv
// Rebuilds Bayer-interleaved 16-pixel beats from sequence-ordered beats via a ping-pong 2x(2*BLOCK_BEATS) word buffer.
// Optional sticky partial_err output is enabled with `define SEQ_TO_BAYER_ERR_EN.
module sequence_to_bayer #(
  parameter int PIXEL_BITS  = 12,
  parameter int BLOCK_BEATS = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [16*PIXEL_BITS-1:0] pixels_input,
  input  logic                     input_valid,
  input  logic                     pause_signal,
  input  logic                     end_in,
  output logic [16*PIXEL_BITS-1:0] pixels_output,
  output logic                     output_valid,
  output logic                     end_out
`ifdef SEQ_TO_BAYER_ERR_EN
  ,
  output logic                     partial_err
`endif
);

  localparam int CW = $clog2(BLOCK_BEATS);
  localparam int WW = 8 * PIXEL_BITS;
  localparam int DW = 16 * PIXEL_BITS;
  localparam int NW = 2 * BLOCK_BEATS;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BEATS - 1);

  logic [WW-1:0] r_bank0 [0:NW-1];
  logic [WW-1:0] r_bank1 [0:NW-1];

  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic          r_wr_bank;
  logic          r_have_block;
  logic          r_end_p1;
  logic          r_vld_p1;
  logic [DW-1:0] r_pix_p1;

  logic          w_accept;
  logic          w_flush;
  logic          w_read;
  logic          w_wrap;
  logic          w_rd_bank;
  logic [CW:0]   w_wr_addr_even;
  logic [CW:0]   w_wr_addr_odd;
  logic [CW:0]   w_rd_addr_a;
  logic [CW:0]   w_rd_addr_b;
  logic [WW-1:0] w_word_a;
  logic [WW-1:0] w_word_b;

  // Output lanes 4m,4m+1 come from word A, 4m+2,4m+3 from word B (lanes 2m,2m+1 of each).
  function automatic logic [DW-1:0] bayer_merge(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int m = 0; m < 4; m++) begin
      r[(4*m)*PIXEL_BITS   +: 2*PIXEL_BITS] = a[(2*m)*PIXEL_BITS +: 2*PIXEL_BITS];
      r[(4*m+2)*PIXEL_BITS +: 2*PIXEL_BITS] = b[(2*m)*PIXEL_BITS +: 2*PIXEL_BITS];
    end
    return r;
  endfunction

  assign w_accept = input_valid & ~pause_signal & ~end_in & ~r_end_p1;
  assign w_flush  = end_in & ~pause_signal & ~r_end_p1;
  assign w_read   = r_have_block & (w_accept | w_flush);
  assign w_wrap   = w_accept & (r_wr_cnt == LAST);

  // Reads always use the bank opposite the writer, so a wrap never collides.
  assign w_rd_bank      = ~r_wr_bank;
  assign w_wr_addr_even = {r_wr_cnt, 1'b0};
  assign w_wr_addr_odd  = {r_wr_cnt, 1'b1};
  assign w_rd_addr_a    = {1'b0, r_rd_cnt};
  assign w_rd_addr_b    = {1'b1, r_rd_cnt};
  assign w_word_a       = w_rd_bank ? r_bank1[w_rd_addr_a] : r_bank0[w_rd_addr_a];
  assign w_word_b       = w_rd_bank ? r_bank1[w_rd_addr_b] : r_bank0[w_rd_addr_b];

  // Stage p0: bank write (storage is never reset).
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && w_accept) begin
      if (r_wr_bank) begin
        r_bank1[w_wr_addr_even] <= pixels_input[WW-1:0];
        r_bank1[w_wr_addr_odd]  <= pixels_input[DW-1:WW];
      end else begin
        r_bank0[w_wr_addr_even] <= pixels_input[WW-1:0];
        r_bank0[w_wr_addr_odd]  <= pixels_input[DW-1:WW];
      end
    end
  end

  // Stage p1: counters, flush sequencing and output register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_wr_bank    <= 1'b0;
      r_have_block <= 1'b0;
      r_end_p1     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_pix_p1     <= '0;
    end else if (!pause_signal) begin
      r_vld_p1 <= w_read;
      if (w_read) begin
        r_pix_p1 <= bayer_merge(w_word_a, w_word_b);
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wrap) begin
          r_wr_bank    <= ~r_wr_bank;
          r_have_block <= 1'b1;
          r_rd_cnt     <= '0;
        end
      end
      // Draining the last beat drops have_block; the next flush cycle raises end_out.
      if (w_flush) begin
        if (!r_have_block) begin
          r_end_p1 <= 1'b1;
        end else if (r_rd_cnt == LAST) begin
          r_have_block <= 1'b0;
        end
      end
    end
  end

  assign pixels_output = r_pix_p1;
  assign output_valid  = r_vld_p1;
  assign end_out       = r_end_p1;

`ifdef SEQ_TO_BAYER_ERR_EN
  logic r_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_err <= 1'b0;
    end else if (!pause_signal) begin
      if ((end_in && (r_wr_cnt != '0)) || (input_valid && r_end_p1)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign partial_err = r_err;
`endif

endmodule

// File: tb/tb_sequence_to_bayer.sv
// Randomized bench for sequence_to_bayer against a queue-based reference of the reorder rules.
module tb_sequence_to_bayer;
  localparam int PB = 12;
  localparam int BB = 32;
  localparam int DW = 16 * PB;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          input_valid;
  logic          pause_signal;
  logic          end_in;
  logic [DW-1:0] pixels_input;
  logic [DW-1:0] pixels_output;
  logic          output_valid;
  logic          end_out;
`ifdef SEQ_TO_BAYER_ERR_EN
  logic          partial_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] beats[$];
  int            n_acc;
  int            n_emit;
  logic          m_valid;
  logic          m_end;
  logic          m_perr;
  logic [DW-1:0] m_data;

  always #5 sys_clk = ~sys_clk;

  sequence_to_bayer #(.PIXEL_BITS(PB), .BLOCK_BEATS(BB)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pixels_input (pixels_input),
    .input_valid  (input_valid),
    .pause_signal (pause_signal),
    .end_in       (end_in),
    .pixels_output(pixels_output),
    .output_valid (output_valid),
    .end_out      (end_out)
`ifdef SEQ_TO_BAYER_ERR_EN
    ,
    .partial_err  (partial_err)
`endif
  );

  // Sequence word w of block b lives in input beat b*BB + w/2, half w%2.
  function automatic logic [PB-1:0] word_lane(int b, int w, int l);
    logic [DW-1:0] t;
    t = beats[b*BB + w/2];
    return t[((w%2)*8 + l)*PB +: PB];
  endfunction

  function automatic logic [DW-1:0] exp_beat(int idx);
    logic [DW-1:0] r;
    int b;
    int i;
    b = idx / BB;
    i = idx % BB;
    for (int m = 0; m < 4; m++) begin
      for (int t = 0; t < 2; t++) begin
        r[(4*m+t)*PB +: PB]   = word_lane(b, i, 2*m+t);
        r[(4*m+2+t)*PB +: PB] = word_lane(b, BB+i, 2*m+t);
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one clock of inputs and advances the reference model; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic iv, input logic p, input logic e, input logic r, input logic [DW-1:0] d);
    int full;
    input_valid  = iv;
    pause_signal = p;
    end_in       = e;
    sys_rst      = r;
    pixels_input = d;
    @(posedge sys_clk);
    if (r) begin
      beats.delete();
      n_acc = 0; n_emit = 0;
      m_valid = 1'b0; m_end = 1'b0; m_perr = 1'b0; m_data = '0;
    end else if (!p) begin
      full = (n_acc / BB) * BB;
      if (m_end) begin
        m_valid = 1'b0;
        if (iv) m_perr = 1'b1;
      end else if (e) begin
        if (n_acc % BB != 0) m_perr = 1'b1;
        if (n_emit < full) begin
          m_valid = 1'b1; m_data = exp_beat(n_emit); n_emit++;
        end else begin
          m_valid = 1'b0; m_end = 1'b1;
        end
      end else if (iv) begin
        beats.push_back(d);
        if (n_acc >= BB) begin
          m_valid = 1'b1; m_data = exp_beat(n_emit); n_emit++;
        end else begin
          m_valid = 1'b0;
        end
        n_acc++;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", output_valid); end
    total++; if (end_out !== 1'b0) begin bad++; $display("FAIL reset_end got=%b want=0", end_out); end
    total++; if (pixels_output !== '0) begin bad++; $display("FAIL reset_pixels got=%h want=0", pixels_output); end
`ifdef SEQ_TO_BAYER_ERR_EN
    total++; if (partial_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", partial_err); end
`endif
  endtask

  task automatic test_identity(input string tag);
    int nv = 0;
    int first = -1;
    logic [DW-1:0] d;
    logic [PB-1:0] w0;
    for (int k = 0; k < 2*BB; k++) begin
      for (int j = 0; j < 16; j++) d[j*PB +: PB] = PB'((32*k + j) % 4096);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, d);
      total++;
      if (output_valid !== m_valid) begin bad++; $display("FAIL %s_valid k=%0d got=%b want=%b", tag, k, output_valid, m_valid); end
      if (output_valid === 1'b1) begin
        if (first < 0) first = k;
        w0 = PB'(32*(nv/2) + 8*(nv%2));
        total++;
        if (pixels_output !== m_data) begin bad++; $display("FAIL %s_data k=%0d got=%h want=%h", tag, k, pixels_output, m_data); end
        total++;
        if (pixels_output[PB-1:0] !== w0 || pixels_output[2*PB-1:PB] !== w0 + 1'b1)
          begin bad++; $display("FAIL %s_lane01 beat=%0d got=%h,%h want=%h,%h", tag, nv, pixels_output[PB-1:0], pixels_output[2*PB-1:PB], w0, w0 + 1'b1); end
        nv++;
      end
    end
    total++; if (first != BB) begin bad++; $display("FAIL %s_first_valid got_accept=%0d want=%0d", tag, first + 1, BB + 1); end
    total++; if (nv != BB) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tag, nv, BB); end
  endtask

  task automatic test_lane_map();
    logic [DW-1:0] d;
    logic [DW-1:0] want;
    for (int m = 0; m < 4; m++) begin
      want[(4*m)*PB +: PB]   = PB'(2*m + 1);
      want[(4*m+1)*PB +: PB] = PB'(2*m + 2);
      want[(4*m+2)*PB +: PB] = PB'(12'h101 + 2*m);
      want[(4*m+3)*PB +: PB] = PB'(12'h102 + 2*m);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < BB + 4; k++) begin
      d = rand_beat();
      if (k == 1)  for (int l = 0; l < 8; l++) d[(8+l)*PB +: PB] = PB'(l + 1);
      if (k == 17) for (int l = 0; l < 8; l++) d[(8+l)*PB +: PB] = PB'(12'h101 + l);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, d);
      if (k == BB + 3) begin
        total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL lanemap_valid got=%b want=1", output_valid); end
        total++; if (pixels_output !== want) begin bad++; $display("FAIL lanemap_beat3 got=%h want=%h", pixels_output, want); end
      end
    end
  endtask

  task automatic test_pause();
    logic [DW-1:0] b7;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
    b7 = exp_beat(7);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_beat());
      total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL pause_valid c=%0d got=%b want=1", c, output_valid); end
      total++; if (pixels_output !== b7) begin bad++; $display("FAIL pause_hold c=%0d got=%h want=%h", c, pixels_output, b7); end
    end
    for (int k = 40; k < 2*BB; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
      if (k == 40) begin
        total++; if (pixels_output !== exp_beat(8)) begin bad++; $display("FAIL pause_resume got=%h want=%h", pixels_output, exp_beat(8)); end
      end
      total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL pause_stream_valid k=%0d got=%b want=1", k, output_valid); end
    end
    for (int c = 0; c < BB + 1; c++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_beat());
      total++; if (output_valid !== m_valid) begin bad++; $display("FAIL pause_flush_valid c=%0d got=%b want=%b", c, output_valid, m_valid); end
      if (m_valid) begin
        total++; if (pixels_output !== m_data) begin bad++; $display("FAIL pause_flush_data c=%0d got=%h want=%h", c, pixels_output, m_data); end
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 2*BB; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
    for (int t = 0; t < BB + 2; t++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_beat());
      if (t < BB) begin
        total++; if (output_valid !== 1'b1) begin bad++; $display("FAIL flush_valid t=%0d got=%b want=1", t, output_valid); end
        total++; if (pixels_output !== exp_beat(BB + t)) begin bad++; $display("FAIL flush_data t=%0d got=%h want=%h", t, pixels_output, exp_beat(BB + t)); end
        total++; if (end_out !== 1'b0) begin bad++; $display("FAIL flush_end_early t=%0d got=%b want=0", t, end_out); end
      end else begin
        total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL flush_tail_valid t=%0d got=%b want=0", t, output_valid); end
        total++; if (end_out !== 1'b1) begin bad++; $display("FAIL flush_end t=%0d got=%b want=1", t, end_out); end
      end
    end
  endtask

  task automatic test_early_end();
    int nv = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
      if (output_valid !== 1'b0) nv++;
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_beat());
    if (output_valid !== 1'b0) nv++;
    total++; if (end_out !== 1'b1) begin bad++; $display("FAIL early_end got=%b want=1", end_out); end
    total++; if (nv != 0) begin bad++; $display("FAIL early_valid_count got=%0d want=0", nv); end
`ifdef SEQ_TO_BAYER_ERR_EN
    total++; if (partial_err !== 1'b1) begin bad++; $display("FAIL early_perr got=%b want=1", partial_err); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 2*BB; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
    for (int t = 0; t < 12; t++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rstflush_valid got=%b want=0", output_valid); end
    total++; if (end_out !== 1'b0) begin bad++; $display("FAIL rstflush_end got=%b want=0", end_out); end
    test_identity("rstflush_ident");
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 260; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'b0, 1'b0, rand_beat());
      total++; if (output_valid !== m_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, output_valid, m_valid); end
      if (m_valid) begin
        total++; if (pixels_output !== m_data) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, pixels_output, m_data); end
      end
    end
    for (int c = 0; c < 3*BB; c++) begin
      cycle($urandom_range(0, 1) != 0, $urandom_range(0, 4) == 0, 1'b1, 1'b0, rand_beat());
      total++; if (output_valid !== m_valid) begin bad++; $display("FAIL rflush_valid c=%0d got=%b want=%b", c, output_valid, m_valid); end
      total++; if (end_out !== m_end) begin bad++; $display("FAIL rflush_end c=%0d got=%b want=%b", c, end_out, m_end); end
      if (m_valid) begin
        total++; if (pixels_output !== m_data) begin bad++; $display("FAIL rflush_data c=%0d got=%h want=%h", c, pixels_output, m_data); end
      end
`ifdef SEQ_TO_BAYER_ERR_EN
      total++; if (partial_err !== m_perr) begin bad++; $display("FAIL rflush_perr c=%0d got=%b want=%b", c, partial_err, m_perr); end
`endif
    end
    total++; if (end_out !== 1'b1) begin bad++; $display("FAIL rflush_done got=%b want=1", end_out); end
  endtask

  initial begin
    input_valid = 1'b0; pause_signal = 1'b0; end_in = 1'b0; sys_rst = 1'b1; pixels_input = '0;
    n_acc = 0; n_emit = 0; m_valid = 1'b0; m_end = 1'b0; m_perr = 1'b0; m_data = '0;
    test_reset();
    test_identity("ident");
    test_lane_map();
    test_pause();
    test_flush();
    test_early_end();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_to_bayer.md
Name: sequence_to_bayer

Overview:
- Inverse of the Bayer-to-sequence reorder stage; sits on the LJPEG decode path, after the lossless decoder and before the raw writer.
- Accepts 16 pixels per beat in sequence order: all even-pair words of a 32-beat block first, then all odd-pair words.
- Rebuilds the original Bayer-interleaved 16-pixel beats through a ping-pong 2x64-word buffer.
- Throughput is one beat per clock, with a latency of one block (BLOCK_BEATS beats).

Parameters:
- PIXEL_BITS, 12, width of one pixel.
- BLOCK_BEATS, 32, beats per reorder block; must be a power of two. Each bank holds 2*BLOCK_BEATS words of 8 pixels.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- pixels_input  in  16*PIXEL_BITS  lane j = bits [j*PIXEL_BITS +: PIXEL_BITS]; lanes 0-7 = sequence word 2k, lanes 8-15 = sequence word 2k+1.
- input_valid  in  1  beat present this cycle.
- pause_signal  in  1  downstream stall; freezes the block.
- end_in  in  1  stream finished; begin flush (level, held high by upstream).
- pixels_output  out  16*PIXEL_BITS  Bayer-ordered beat, same lane packing as the input.
- output_valid  out  1  pixels_output is valid this cycle.
- end_out  out  1  flush complete; sticky.

Behaviour:
- **Reset:** sys_rst is synchronous and active-high. It clears the following:
  - pixels_output=0, output_valid=0, end_out=0
  - wr_cnt=0, wr_bank=0, have_block=0, flush_cnt=0
  - Bank contents are not cleared.
  - Reset mid-block or mid-flush discards everything.
- **Accept:**
  - A beat is accepted when input_valid & ~pause_signal & ~end_in.
  - Word lanes 0-7 is written to bank[wr_bank] at address 2*wr_cnt; lanes 8-15 at address 2*wr_cnt+1.
  - wr_cnt increments modulo BLOCK_BEATS.
  - When wr_cnt wraps (BLOCK_BEATS-1 -> 0): wr_bank toggles, have_block is set to 1, and rd_cnt is set to 0.
- **Read mapping:** output beat i of a completed block takes A=word i and B=word BLOCK_BEATS+i of the read bank (rd_bank = ~wr_bank).
  - Output lanes 4m, 4m+1 = A lanes 2m, 2m+1.
  - Output lanes 4m+2, 4m+3 = B lanes 2m, 2m+1.
  - This holds for m = 0..3.
- **Emit:**
  - On each accepted beat with have_block=1, the next cycle shows the beat for rd_cnt with output_valid=1, and rd_cnt increments.
  - An accepted beat with have_block=0 gives output_valid=0 on the next cycle.
  - A non-paused cycle with no accept and no flush gives output_valid=0.
  - Latency is one clock from the accept to the output register.
- **Pause:**
  - While pause_signal=1, all state and all outputs hold their values, including output_valid and pixels_output.
  - Bank writes are inhibited.
  - A read issued before the pause is preserved in the output register.
- **Flush (end_in=1, ~pause_signal):**
  - Sources: writes stop, and input_valid is ignored.
  - If have_block=1, one beat per cycle is emitted from the read bank, rd_cnt through BLOCK_BEATS-1, with output_valid=1.
  - After the last beat: end_out=1 and output_valid=0 on the following cycle.
  - If have_block=0, end_out=1 on the next cycle and no beats are emitted.
  - A partial block (wr_cnt!=0) at end_in is discarded. Upstream guarantees whole blocks.
  - Pause during flush freezes the flush.
- **Rollover:** at block wrap, reads and writes both move bank in the same cycle. The last read of the old read bank and the first write of the new write bank never target the same bank.
- **Simultaneous events:** end_in has priority over input_valid. pause_signal has priority over both. sys_rst has priority over all.
- After end_out=1, the block stays idle until sys_rst.

Optional Feature:
- Macro: SEQ_TO_BAYER_ERR_EN.
- **When defined:**
  - Adds port partial_err (out, 1), with reset value 0.
  - partial_err is set sticky when end_in is first seen with wr_cnt!=0.
  - It also sets on input_valid=1 while end_out=1.
  - It clears only on sys_rst.
- **When undefined:** the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- **Identity block:** send 64 beats; beat k has lane j = 32*k+j mod 4096. Required results:
  - output_valid is first asserted on the cycle after accept 33.
  - Output beat i lanes 0,1 = A[0],A[1] where A = input beat i/2, half i%2.
  - 32 outputs per block.
- **Lane mapping:** in block 0, set word 3 = 0x001..0x008 and word 35 = 0x101..0x108. Required output beat 3 = 0x001,0x002,0x101,0x102,0x003,0x004,0x103,0x104,…,0x107,0x108.
- **Pause mid-stream:**
  - Send 40 beats, then assert pause for 5 cycles with input_valid=1.
  - Outputs must hold the beat-7 value and output_valid=1 for those 5 cycles.
  - Resume yields beat 8 with no loss or duplication.
- **Flush:**
  - After 2 full blocks, hold end_in=1.
  - Exactly 32 beats of block 1 are emitted on consecutive cycles, then end_out=1 with output_valid=0.
  - Input beats during the flush are ignored.
- **Early end:** end_in after 10 beats (no full block) gives end_out=1 on the next cycle with zero valid outputs. With SEQ_TO_BAYER_ERR_EN, partial_err=1.
- **Reset mid-flush:** assert sys_rst at flush beat 12. Next cycle: output_valid=0, end_out=0. A fresh 64-beat stream then reproduces the identity-block results exactly.
